// File: rtl/sha2_conduit_regs_if.sv
`timescale 1ns/1ps
// sha2_conduit_regs_if
//   Bundles the conduit register bus, the message stream towards the SHA2
//   core and the core control/digest signals of sha2_conduit_regs.
//   Ports (all in the interface):
//     con_wr/con_rd, con_waddr/con_raddr, con_wdata, con_wbyte_enable,
//     con_rbyte_enable, con_rd_ack      : request side (master drives)
//     con_wr_ack, con_rdata, con_read_valid, con_slv_error : response side
//     msg_valid, msg_data, msg_last / msg_ready : message stream to the core
//     core_start / digest_valid, digest : core control and result
//   Modports: master = bus requester / core side, slave = register block.
interface sha2_conduit_regs_if #(
    parameter int D_WIDTH = 32
);
    logic                   con_wr;
    logic                   con_rd;
    logic [11:0]            con_waddr;
    logic [11:0]            con_raddr;
    logic [D_WIDTH-1:0]     con_wdata;
    logic [D_WIDTH/8-1:0]   con_wbyte_enable;
    logic [D_WIDTH/8-1:0]   con_rbyte_enable;
    logic                   con_rd_ack;
    logic                   con_wr_ack;
    logic [D_WIDTH-1:0]     con_rdata;
    logic                   con_read_valid;
    logic                   con_slv_error;
    logic                   msg_valid;
    logic                   msg_ready;
    logic [31:0]            msg_data;
    logic                   msg_last;
    logic                   core_start;
    logic                   digest_valid;
    logic [255:0]           digest;

    modport master (
        output con_wr, con_rd, con_waddr, con_raddr, con_wdata,
               con_wbyte_enable, con_rbyte_enable, con_rd_ack,
               msg_ready, digest_valid, digest,
        input  con_wr_ack, con_rdata, con_read_valid, con_slv_error,
               msg_valid, msg_data, msg_last, core_start
    );

    modport slave (
        input  con_wr, con_rd, con_waddr, con_raddr, con_wdata,
               con_wbyte_enable, con_rbyte_enable, con_rd_ack,
               msg_ready, digest_valid, digest,
        output con_wr_ack, con_rdata, con_read_valid, con_slv_error,
               msg_valid, msg_data, msg_last, core_start
    );
endinterface

// File: rtl/sha2_conduit_regs.sv
`timescale 1ns/1ps
// sha2_conduit_regs
//   Conduit-bus register block in front of a SHA2 core: a message FIFO
//   (word + last flag) feeding the core stream, START/FLUSH control and a
//   latched 256-bit digest readable as eight 32-bit registers.
//   Ports:
//     pclk     : clock, rising edge
//     presetn  : asynchronous active-low reset
//     bus      : sha2_conduit_regs_if.slave (conduit bus, message stream,
//                core_start, digest input)
//   Register map: 0x000 CTRL (W), 0x004 STATUS (R), 0x008 MSG_DATA (W),
//                 0x00C MSG_LAST (W), 0x040..0x05C DIGEST0..7 (R).
//   Build option: define SHA2_REGS_WR_TIMEOUT_EN to abort a push stalled on
//   a full FIFO after 16 cycles with a slave error.
module sha2_conduit_regs #(
    parameter int D_WIDTH    = 32,
    parameter int FIFO_DEPTH = 16
) (
    input logic              pclk,
    input logic              presetn,
    sha2_conduit_regs_if.slave bus
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_STATUS = 12'h004;
    localparam logic [11:0] A_MSG    = 12'h008;
    localparam logic [11:0] A_LAST   = 12'h00C;

    typedef enum logic [1:0] {IDLE, RESP, WR_WAIT} state_t;

    state_t         state;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic [32:0]    mem [FIFO_DEPTH];
    logic [255:0]   digest_q;
    logic           digest_ready;
    logic [11:0]    pend_addr;
    logic [31:0]    pend_data;
    logic           wr_ack_q;
    logic           read_valid_q;
    logic           slv_error_q;
    logic           core_start_q;
`ifdef SHA2_REGS_WR_TIMEOUT_EN
    logic [3:0]     tcnt;
`endif

    logic           w_ctrl, w_push, w_err, r_dig, r_ok;
    logic           empty, full, pop, can_push, wr_go, ctrl_go;
    logic           do_flush, do_start, do_push;
    logic [31:0]    push_word;
    logic           push_last;
    logic [32:0]    head;
    logic [31:0]    dig_w [8];
    logic [D_WIDTH-1:0] rdata;
    logic           unused_inputs;

    assign unused_inputs = ^{bus.con_rd_ack, bus.con_rbyte_enable};

    // Access decode on the live request
    assign w_ctrl = (bus.con_waddr == A_CTRL);
    assign w_push = (bus.con_waddr == A_MSG) || (bus.con_waddr == A_LAST);
    assign w_err  = !(w_ctrl || w_push)
                  || (w_push && (bus.con_wbyte_enable != 4'hF))
                  || (w_ctrl && (bus.con_wbyte_enable[3:1] != 3'b000));
    assign r_dig  = (bus.con_raddr[11:5] == 7'h02) && (bus.con_raddr[1:0] == 2'b00);
    assign r_ok   = (bus.con_raddr == A_STATUS) || r_dig;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop      = !empty && bus.msg_ready;
    // A push into a full FIFO still fits when a pop happens in the same cycle
    assign can_push = !full || pop;

    assign wr_go    = (state == IDLE) && bus.con_wr;
    assign ctrl_go  = wr_go && w_ctrl && !w_err && bus.con_wbyte_enable[0];
    assign do_flush = ctrl_go && bus.con_wdata[1];
    assign do_start = ctrl_go && bus.con_wdata[0];

    always_comb begin
        do_push   = 1'b0;
        push_word = bus.con_wdata;
        push_last = (bus.con_waddr == A_LAST);
        if (wr_go && w_push && !w_err && can_push) begin
            do_push = 1'b1;
        end else if ((state == WR_WAIT) && can_push) begin
            do_push   = 1'b1;
            push_word = pend_data;
            push_last = (pend_addr == A_LAST);
        end
    end

    assign head          = mem[rd_ptr];
    assign bus.msg_valid = !empty;
    assign bus.msg_data  = head[31:0];
    assign bus.msg_last  = head[32];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dig_w[i] = digest_q[255 - 32*i -: 32];
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.con_raddr == A_STATUS) begin
            rdata[0]    = empty;
            rdata[1]    = full;
            rdata[2]    = digest_ready;
            rdata[10:4] = 7'(count);
        end else if (r_dig) begin
            rdata = dig_w[bus.con_raddr[4:2]];
        end
    end

    assign bus.con_rdata      = rdata;
    assign bus.con_wr_ack     = wr_ack_q;
    assign bus.con_read_valid = read_valid_q;
    assign bus.con_slv_error  = slv_error_q;
    assign bus.core_start     = core_start_q;

    // Storage without reset: FIFO array and the held write
    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr] <= {push_last, push_word};
        if (wr_go) begin
            pend_addr <= bus.con_waddr;
            pend_data <= bus.con_wdata;
        end
    end

    // Control state: FIFO pointers, digest, access FSM
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            digest_q     <= '0;
            digest_ready <= 1'b0;
            wr_ack_q     <= 1'b0;
            read_valid_q <= 1'b0;
            slv_error_q  <= 1'b0;
            core_start_q <= 1'b0;
`ifdef SHA2_REGS_WR_TIMEOUT_EN
            tcnt         <= '0;
`endif
        end else begin
            core_start_q <= do_start;

            // FLUSH overrides any pop in the same cycle
            if (do_flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
                if (do_push && !pop)      count <= count + CNT_ONE;
                else if (!do_push && pop) count <= count - CNT_ONE;
            end

            // A digest arriving together with START keeps digest_ready set
            if (bus.digest_valid) begin
                digest_q     <= bus.digest;
                digest_ready <= 1'b1;
            end else if (do_start) begin
                digest_ready <= 1'b0;
            end

            wr_ack_q     <= 1'b0;
            read_valid_q <= 1'b0;
            slv_error_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.con_wr) begin
                        if (w_err) begin
                            slv_error_q <= 1'b1;
                            state       <= RESP;
                        end else if (w_push && !can_push) begin
                            state <= WR_WAIT;
`ifdef SHA2_REGS_WR_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else begin
                            wr_ack_q <= 1'b1;
                            state    <= RESP;
                        end
                    end else if (bus.con_rd) begin
                        if (r_ok) read_valid_q <= 1'b1;
                        else      slv_error_q  <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                WR_WAIT: begin
                    if (can_push) begin
                        wr_ack_q <= 1'b1;
                        state    <= RESP;
                    end
`ifdef SHA2_REGS_WR_TIMEOUT_EN
                    else if (tcnt == 4'd15) begin
                        slv_error_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tcnt <= tcnt + 4'd1;
                    end
`else
                    else begin
                        state <= WR_WAIT;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha2_conduit_regs.sv
`timescale 1ns/1ps
// tb_sha2_conduit_regs
//   Directed bench for sha2_conduit_regs. A transaction-level model (queue
//   of expected message words, digest word array, digest_ready flag) tracks
//   the register block; a negedge process compares the message stream
//   against the queue every cycle, and the directed tasks compare bus
//   responses and read data against hand-computed values.
module tb_sha2_conduit_regs;
    localparam logic [2:0] RV  = 3'b100;
    localparam logic [2:0] ACK = 3'b010;
    localparam logic [2:0] ERR = 3'b001;
    localparam logic [255:0] DIG =
        256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;

    logic pclk    = 1'b0;
    logic presetn = 1'b1;
    always #5 pclk = ~pclk;

    sha2_conduit_regs_if #(.D_WIDTH(32)) bus();

    sha2_conduit_regs #(.D_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    logic [31:0] m_dig [8];
    logic        m_rdy = 1'b0;
    int          pops = 0;
    int          n_last = 0;
    int          last_pos = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] strobes();
        return {bus.con_read_valid, bus.con_wr_ack, bus.con_slv_error};
    endfunction

    function automatic logic [31:0] status_exp();
        int c = exp_q.size();
        return {21'b0, 7'(c), 1'b0, m_rdy, (c == 16), (c == 0)};
    endfunction

    // Model effect of an accepted write (CTRL writes use byte0 only)
    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h008 || a == 12'h00C) exp_q.push_back({(a == 12'h00C), d});
        if (a == 12'h000) begin
            if (d[1]) exp_q.delete();
            if (d[0]) m_rdy = 1'b0;
        end
    endtask

    // Message stream scoreboard
    always @(negedge pclk) begin
        check("msg_valid", {63'b0, bus.msg_valid}, {63'b0, (exp_q.size() != 0)});
        if (bus.msg_valid && exp_q.size() != 0) begin
            check("msg_word", {31'b0, bus.msg_last, bus.msg_data}, {31'b0, exp_q[0]});
            if (bus.msg_ready) begin
                void'(exp_q.pop_front());
                pops++;
                if (bus.msg_last) begin
                    n_last++;
                    last_pos = pops;
                end
            end
        end
    end

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [2:0] exp_resp, input string name);
        logic exp_start;
        @(posedge pclk); #1;
        bus.con_wr = 1'b1; bus.con_waddr = a; bus.con_wdata = d; bus.con_wbyte_enable = be;
        @(posedge pclk); #1;
        bus.con_wr = 1'b0;
        if (exp_resp == ACK) model_write(a, d);
        exp_start = (exp_resp == ACK) && (a == 12'h000) && d[0];
        @(negedge pclk);
        check({name, "_resp"}, 64'(strobes()), 64'(exp_resp));
        check({name, "_core_start"}, 64'(bus.core_start), 64'(exp_start));
        @(negedge pclk);
        check({name, "_idle"}, 64'({strobes(), bus.core_start}), 64'(0));
    endtask

    task automatic rd(input logic [11:0] a, input logic [2:0] exp_resp,
                      input logic [31:0] exp_data, input string name);
        @(posedge pclk); #1;
        bus.con_rd = 1'b1; bus.con_raddr = a;
        @(posedge pclk); #1;
        bus.con_rd = 1'b0;
        @(negedge pclk);
        check({name, "_resp"}, 64'(strobes()), 64'(exp_resp));
        check({name, "_data"}, 64'(bus.con_rdata), 64'(exp_data));
        @(negedge pclk);
        check({name, "_idle"}, 64'(strobes()), 64'(0));
    endtask

    task automatic fill(input int n);
        for (int i = 1; i <= n; i++)
            wr((i == n) ? 12'h00C : 12'h008, 32'hA000_0000 | 32'(i), 4'hF, ACK, "push");
    endtask

    task automatic drain();
        @(posedge pclk); #1;
        bus.msg_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge pclk);
        @(posedge pclk); #1;
        bus.msg_ready = 1'b0;
        check("drain_done", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic clear_counts();
        pops = 0; n_last = 0; last_pos = 0;
    endtask

    // Push a word into a full FIFO (drive only; the caller observes the stall)
    task automatic push_into_full(input logic [31:0] d);
        @(posedge pclk); #1;
        bus.con_wr = 1'b1; bus.con_waddr = 12'h008; bus.con_wdata = d; bus.con_wbyte_enable = 4'hF;
        @(posedge pclk); #1;
        bus.con_wr = 1'b0;
        exp_q.push_back({1'b0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [2:0] resp;
        bus.con_wr = 0; bus.con_rd = 0; bus.con_waddr = 0; bus.con_raddr = 0;
        bus.con_wdata = 0; bus.con_wbyte_enable = 0; bus.con_rbyte_enable = 4'hF;
        bus.con_rd_ack = 0; bus.msg_ready = 0; bus.digest_valid = 0; bus.digest = '0;
        for (int i = 0; i < 8; i++) m_dig[i] = '0;

        // Reset
        #2 presetn = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            check("reset_outputs", 64'({strobes(), bus.core_start, bus.msg_valid}), 64'(0));
        end
        @(posedge pclk); #1 presetn = 1'b1;
        rd(12'h004, RV, 32'h0000_0001, "status_after_reset");

        // Fill to full, then drain: last flag only on word 16
        clear_counts();
        fill(16);
        rd(12'h004, RV, 32'h0000_0102, "status_full");
        drain();
        check("pops_a", 64'(pops), 64'(16));
        check("last_count_a", 64'(n_last), 64'(1));
        check("last_pos_a", 64'(last_pos), 64'(16));

        // Push into a full FIFO
        clear_counts();
        fill(16);
        push_into_full(32'hB000_0017);
`ifdef SHA2_REGS_WR_TIMEOUT_EN
        lat = 0; resp = 3'b000;
        for (int k = 1; k <= 20; k++) begin
            @(negedge pclk);
            if (strobes() != 3'b000) begin
                lat = k; resp = strobes();
                break;
            end
        end
        check("timeout_latency", 64'(lat), 64'(17));
        check("timeout_resp", 64'(resp), 64'(ERR));
        void'(exp_q.pop_back());
        rd(12'h004, RV, 32'h0000_0102, "status_after_timeout");
        drain();
        check("pops_b", 64'(pops), 64'(16));
`else
        repeat (5) begin
            @(negedge pclk);
            check("stall_quiet", 64'(strobes()), 64'(0));
        end
        @(posedge pclk); #1 bus.msg_ready = 1'b1;
        @(negedge pclk);
        check("stall_pop_cycle", 64'(strobes()), 64'(0));
        @(negedge pclk);
        check("stall_ack", 64'(strobes()), 64'(ACK));
        drain();
        check("pops_b", 64'(pops), 64'(17));
`endif
        check("last_pos_b", 64'(last_pos), 64'(16));

        // FLUSH, then START+FLUSH together
        fill(3);
        wr(12'h000, 32'h2, 4'h1, ACK, "flush");
        rd(12'h004, RV, 32'h0000_0001, "status_after_flush");
        fill(2);
        wr(12'h000, 32'h3, 4'h1, ACK, "start_flush");
        rd(12'h004, RV, 32'h0000_0001, "status_after_start_flush");

        // Digest strobe in the same cycle as a START write
        @(posedge pclk); #1;
        bus.con_wr = 1'b1; bus.con_waddr = 12'h000; bus.con_wdata = 32'h1; bus.con_wbyte_enable = 4'h1;
        bus.digest_valid = 1'b1; bus.digest = DIG;
        @(posedge pclk); #1;
        bus.con_wr = 1'b0; bus.digest_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_dig[i] = DIG[255 - 32*i -: 32];
        m_rdy = 1'b1;
        @(negedge pclk);
        check("dig_start_resp", 64'(strobes()), 64'(ACK));
        check("dig_core_start", 64'(bus.core_start), 64'(1));
        @(negedge pclk);
        check("dig_core_start_end", 64'(bus.core_start), 64'(0));
        rd(12'h004, RV, 32'h0000_0005, "status_digest_ready");
        rd(12'h040, RV, 32'h0102_0304, "digest0");
        rd(12'h05C, RV, 32'h1d1e_1f20, "digest7");
        rd(12'h050, RV, m_dig[4], "digest4_model");

        // Error accesses change nothing
        fill(2);
        wr(12'h008, 32'hDEAD_0001, 4'h3, ERR, "push_partial_be");
        rd(12'h060, ERR, 32'h0, "read_unmapped");
        wr(12'h040, 32'hDEAD_0002, 4'hF, ERR, "write_digest");
        wr(12'h000, 32'h3, 4'h2, ERR, "ctrl_byte1");
        wr(12'h004, 32'h2, 4'hF, ERR, "write_status");
        rd(12'h008, ERR, 32'h0, "read_msg_data");
        rd(12'h004, RV, 32'h0000_0024, "status_after_errors");
        rd(12'h004, RV, status_exp(), "status_model");
        rd(12'h050, RV, 32'h1112_1314, "digest4");

        // START alone clears digest_ready, digest kept
        wr(12'h000, 32'h1, 4'h1, ACK, "start");
        rd(12'h004, RV, 32'h0000_0020, "status_after_start");
        rd(12'h040, RV, 32'h0102_0304, "digest0_kept");
        drain();

        // Reset while a push is stalled on a full FIFO
        fill(16);
        push_into_full(32'hC000_0017);
        repeat (3) @(negedge pclk);
        @(posedge pclk); #1;
        presetn = 1'b0;
        exp_q.delete();
        m_rdy = 1'b0;
        for (int i = 0; i < 8; i++) m_dig[i] = '0;
        repeat (3) begin
            @(negedge pclk);
            check("reset_mid_outputs", 64'({strobes(), bus.core_start}), 64'(0));
        end
        @(posedge pclk); #1 presetn = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            check("no_ack_after_reset", 64'(strobes()), 64'(0));
        end
        rd(12'h004, RV, 32'h0000_0001, "status_after_mid_reset");
        rd(12'h040, RV, 32'h0, "digest0_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
